// File: rtl/rv32i_pkg.sv
// Shared constants for the RV32I execute stage: field widths, one-hot bit
// positions for ALU ops and opcodes, exception flag positions, and the
// bundle of combinational results handed from datapath to pipeline regs.
package rv32i_pkg;

    localparam int ALU_WIDTH       = 14;
    localparam int OPCODE_WIDTH    = 11;
    localparam int EXCEPTION_WIDTH = 4;

    // One-hot ALU operation bit positions
    localparam int ADD  = 0;
    localparam int SUB  = 1;
    localparam int SLT  = 2;
    localparam int SLTU = 3;
    localparam int XOR  = 4;
    localparam int OR   = 5;
    localparam int AND  = 6;
    localparam int SLL  = 7;
    localparam int SRL  = 8;
    localparam int SRA  = 9;
    localparam int EQ   = 10;
    localparam int NEQ  = 11;
    localparam int GE   = 12;
    localparam int GEU  = 13;

    // One-hot opcode bit positions
    localparam int RTYPE  = 0;
    localparam int ITYPE  = 1;
    localparam int LOAD   = 2;
    localparam int STORE  = 3;
    localparam int BRANCH = 4;
    localparam int JAL    = 5;
    localparam int JALR   = 6;
    localparam int LUI    = 7;
    localparam int AUIPC  = 8;
    localparam int SYSTEM = 9;
    localparam int FENCE  = 10;

    // Exception flag positions (carried through untouched)
    localparam int EXC_ILLEGAL = 0;
    localparam int EXC_ECALL   = 1;
    localparam int EXC_EBREAK  = 2;
    localparam int EXC_MRET    = 3;

    // Combinational results of the execute datapath
    typedef struct packed {
        logic [31:0] y;
        logic [31:0] rd;
        logic [31:0] next_pc;
        logic        change_pc;
    } dp_result_t;

endpackage

// File: rtl/rv32i_alu_datapath.sv
// Pure combinational execute datapath: operand selection, one-hot ALU,
// writeback data and branch/jump target resolution.
module rv32i_alu_datapath
    import rv32i_pkg::*;
(
    input  logic [ALU_WIDTH-1:0]    alu,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [31:0]             rs1,
    input  logic [31:0]             rs2,
    input  logic [31:0]             imm,
    input  logic [31:0]             pc,
    output dp_result_t              res
);

    logic [31:0] a_s;
    logic [31:0] b_s;
    logic [31:0] y_s;

    // Operand select: PC-relative ops use pc as a; register-register and branches use rs2 as b
    always_comb begin
        a_s = rs1;
        b_s = imm;
        if (opcode[JAL] | opcode[AUIPC]) begin
            a_s = pc;
        end else begin
            a_s = rs1;
        end
        if (opcode[RTYPE] | opcode[BRANCH]) begin
            b_s = rs2;
        end else begin
            b_s = imm;
        end
    end

    // ALU: priority chain so an illegal multi-hot select resolves to its lowest bit
    always_comb begin
        y_s = 32'd0;
        if      (alu[ADD])  y_s = a_s + b_s;
        else if (alu[SUB])  y_s = a_s - b_s;
        else if (alu[SLT])  y_s = {31'd0, $signed(a_s) < $signed(b_s)};
        else if (alu[SLTU]) y_s = {31'd0, a_s < b_s};
        else if (alu[XOR])  y_s = a_s ^ b_s;
        else if (alu[OR])   y_s = a_s | b_s;
        else if (alu[AND])  y_s = a_s & b_s;
        else if (alu[SLL])  y_s = a_s << b_s[4:0];
        else if (alu[SRL])  y_s = a_s >> b_s[4:0];
        else if (alu[SRA])  y_s = $signed(a_s) >>> b_s[4:0];
        else if (alu[EQ])   y_s = {31'd0, a_s == b_s};
        else if (alu[NEQ])  y_s = {31'd0, a_s != b_s};
        else if (alu[GE])   y_s = {31'd0, $signed(a_s) >= $signed(b_s)};
        else if (alu[GEU])  y_s = {31'd0, a_s >= b_s};
        else                y_s = 32'd0;
    end

    // Writeback data, redirect target and redirect decision
    always_comb begin
        res.y = y_s;
        if      (opcode[LUI])                res.rd = imm;
        else if (opcode[AUIPC])              res.rd = pc + imm;
        else if (opcode[JAL] | opcode[JALR]) res.rd = pc + 32'd4;
        else                                 res.rd = y_s;
        if (opcode[JALR]) begin
            res.next_pc = (rs1 + imm) & ~32'd1;
        end else begin
            res.next_pc = pc + imm;
        end
        res.change_pc = opcode[JAL] | opcode[JALR] | (opcode[BRANCH] & y_s[0]);
    end

endmodule

// File: rtl/rv32i_alu_exec.sv
// RV32I execute stage: wraps the combinational datapath with the pipeline
// register toward the memory stage and the stall/flush handshake.
module rv32i_alu_exec
    import rv32i_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [ALU_WIDTH-1:0]       i_alu,
    input  logic [OPCODE_WIDTH-1:0]    i_opcode,
    input  logic [2:0]                 i_funct3,
    input  logic [4:0]                 i_rs1_addr,
    input  logic [31:0]                i_rs1,
    input  logic [31:0]                i_rs2,
    input  logic [31:0]                i_imm,
    input  logic [31:0]                i_pc,
    input  logic [4:0]                 i_rd_addr,
    input  logic [EXCEPTION_WIDTH-1:0] i_exception,
    input  logic                       i_ce,
    input  logic                       i_stall,
    input  logic                       i_force_stall,
    input  logic                       i_flush,
    output logic [4:0]                 o_rs1_addr,
    output logic [31:0]                o_rs1,
    output logic [31:0]                o_rs2,
    output logic [11:0]                o_imm,
    output logic [2:0]                 o_funct3,
    output logic [OPCODE_WIDTH-1:0]    o_opcode,
    output logic [EXCEPTION_WIDTH-1:0] o_exception,
    output logic [31:0]                o_pc,
    output logic [31:0]                o_y,
    output logic [31:0]                o_next_pc,
    output logic                       o_change_pc,
    output logic                       o_wr_rd,
    output logic [4:0]                 o_rd_addr,
    output logic [31:0]                o_rd,
    output logic                       o_rd_valid,
    output logic                       o_stall_from_alu,
    output logic                       o_ce,
    output logic                       o_stall,
    output logic                       o_flush
);

    dp_result_t dp_s;
    logic       stall_bit_s;
    logic       fire_s;
    logic       wr_rd_s;
    logic       rd_valid_s;

    rv32i_alu_datapath u_datapath (
        .alu    (i_alu),
        .opcode (i_opcode),
        .rs1    (i_rs1),
        .rs2    (i_rs2),
        .imm    (i_imm),
        .pc     (i_pc),
        .res    (dp_s)
    );

    // Upstream handshake; a flush overrides the stall we report, but a real
    // downstream stall still freezes this stage through stall_bit_s
    always_comb begin
        o_stall     = (i_stall | i_force_stall) & ~i_flush;
        o_flush     = i_flush;
        stall_bit_s = o_stall | i_stall;
        fire_s      = i_ce & ~stall_bit_s;
        wr_rd_s     = ~(i_opcode[BRANCH] | i_opcode[STORE] | i_opcode[FENCE] |
                        (i_opcode[SYSTEM] & (i_funct3 == 3'd0)));
        rd_valid_s  = wr_rd_s & ~i_opcode[LOAD];
    end

    // Data pipeline register: loads on an accepted instruction, otherwise holds
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_rs1_addr  <= 5'd0;
            o_rs1       <= 32'd0;
            o_rs2       <= 32'd0;
            o_imm       <= 12'd0;
            o_funct3    <= 3'd0;
            o_opcode    <= {OPCODE_WIDTH{1'b0}};
            o_exception <= {EXCEPTION_WIDTH{1'b0}};
            o_pc        <= 32'd0;
            o_y         <= 32'd0;
            o_next_pc   <= 32'd0;
            o_rd_addr   <= 5'd0;
            o_rd        <= 32'd0;
        end else if (fire_s) begin
            o_rs1_addr  <= i_rs1_addr;
            o_rs1       <= i_rs1;
            o_rs2       <= i_rs2;
            o_imm       <= i_imm[11:0];
            o_funct3    <= i_funct3;
            o_opcode    <= i_opcode;
            o_exception <= i_exception;
            o_pc        <= i_pc;
            o_y         <= dp_s.y;
            o_next_pc   <= dp_s.next_pc;
            o_rd_addr   <= i_rd_addr;
            o_rd        <= dp_s.rd;
        end
    end

    // Control flags: redirect is a one-cycle pulse, the rest hold when not loading
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_change_pc      <= 1'b0;
            o_wr_rd          <= 1'b0;
            o_rd_valid       <= 1'b0;
            o_stall_from_alu <= 1'b0;
        end else if (fire_s) begin
            o_change_pc      <= dp_s.change_pc;
            o_wr_rd          <= wr_rd_s;
            o_rd_valid       <= rd_valid_s;
            o_stall_from_alu <= i_opcode[LOAD] | i_opcode[STORE];
        end else begin
            o_change_pc      <= 1'b0;
        end
    end

    // Next-stage valid: flush kills, a released downstream stall inserts a bubble
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_ce <= 1'b0;
        end else if (i_flush & ~stall_bit_s) begin
            o_ce <= 1'b0;
        end else if (~stall_bit_s) begin
            o_ce <= i_ce;
        end else if (~i_stall) begin
            o_ce <= 1'b0;
        end else begin
            o_ce <= o_ce;
        end
    end

endmodule

// File: tb/tb_rv32i_alu_exec.sv
// Self-checking bench for rv32i_alu_exec: directed cases with literal
// expectations followed by randomized vectors against a behavioural model.
module tb_rv32i_alu_exec;

    // Local one-hot positions (kept independent of the design package)
    localparam int T_ADD = 0, T_SUB = 1, T_SLT = 2, T_SLTU = 3, T_SRA = 9, T_EQ = 10;
    localparam int T_RTYPE = 0, T_ITYPE = 1, T_LOAD = 2, T_STORE = 3, T_BRANCH = 4;
    localparam int T_JAL = 5, T_JALR = 6, T_LUI = 7, T_AUIPC = 8, T_SYSTEM = 9, T_FENCE = 10;

    logic        clk;
    logic        rst_n;
    logic [13:0] alu;
    logic [10:0] opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1_addr, rd_addr;
    logic [31:0] rs1, rs2, imm, pc;
    logic [3:0]  exception;
    logic        ce, stall, force_stall, flush;

    logic [4:0]  o_rs1_addr, o_rd_addr;
    logic [31:0] o_rs1, o_rs2, o_pc, o_y, o_next_pc, o_rd;
    logic [11:0] o_imm;
    logic [2:0]  o_funct3;
    logic [10:0] o_opcode;
    logic [3:0]  o_exception;
    logic        o_change_pc, o_wr_rd, o_rd_valid, o_stall_from_alu, o_ce, o_stall, o_flush;

    int n_vec;
    int n_err;

    // Expected registered state
    logic [31:0] e_y, e_rd, e_next_pc, e_rs1, e_rs2, e_pc;
    logic [11:0] e_imm;
    logic [4:0]  e_rs1_addr, e_rd_addr;
    logic [2:0]  e_funct3;
    logic [10:0] e_opcode;
    logic [3:0]  e_exception;
    logic        e_change_pc, e_wr_rd, e_rd_valid, e_sfa, e_ce, e_np_known;

    rv32i_alu_exec dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_alu(alu), .i_opcode(opcode), .i_funct3(funct3),
        .i_rs1_addr(rs1_addr), .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm), .i_pc(pc),
        .i_rd_addr(rd_addr), .i_exception(exception), .i_ce(ce), .i_stall(stall),
        .i_force_stall(force_stall), .i_flush(flush),
        .o_rs1_addr(o_rs1_addr), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_imm(o_imm),
        .o_funct3(o_funct3), .o_opcode(o_opcode), .o_exception(o_exception), .o_pc(o_pc),
        .o_y(o_y), .o_next_pc(o_next_pc), .o_change_pc(o_change_pc), .o_wr_rd(o_wr_rd),
        .o_rd_addr(o_rd_addr), .o_rd(o_rd), .o_rd_valid(o_rd_valid),
        .o_stall_from_alu(o_stall_from_alu), .o_ce(o_ce), .o_stall(o_stall), .o_flush(o_flush)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int low_idx(input logic [13:0] v);
        int r;
        r = -1;
        for (int i = 13; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    // Reference ALU from the instruction-set meaning of each operation
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        int sh;
        sa = a;
        sb = b;
        sh = int'(b % 32'd32);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return (sa < sb) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a ^ b;
            5:  return a | b;
            6:  return a & b;
            7:  return a * (32'd1 << sh);
            8:  return a / (32'd1 << sh);
            9:  return sa >>> sh;
            10: return (a == b) ? 32'd1 : 32'd0;
            11: return (a != b) ? 32'd1 : 32'd0;
            12: return (sa >= sb) ? 32'd1 : 32'd0;
            13: return (a >= b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Apply current inputs for one clock, advance the model, compare everything
    task automatic step();
        logic up, any, fire;
        logic [31:0] a, b, y;
        up   = (stall | force_stall) & ~flush;
        any  = up | stall;
        fire = ce & ~any;
        #1;
        chk("o_stall", {31'd0, o_stall}, {31'd0, up});
        chk("o_flush", {31'd0, o_flush}, {31'd0, flush});
        if (!rst_n) begin
            {e_y, e_rd, e_next_pc, e_rs1, e_rs2, e_pc} = '0;
            {e_imm, e_rs1_addr, e_rd_addr, e_funct3, e_opcode, e_exception} = '0;
            {e_change_pc, e_wr_rd, e_rd_valid, e_sfa, e_ce} = '0;
            e_np_known = 1'b1;
        end else begin
            if (fire) begin
                a = (opcode[T_JAL] || opcode[T_AUIPC]) ? pc : rs1;
                b = (opcode[T_RTYPE] || opcode[T_BRANCH]) ? rs2 : imm;
                y = ref_alu(low_idx(alu), a, b);
                e_y = y;
                if (opcode[T_LUI])                      e_rd = imm;
                else if (opcode[T_AUIPC])               e_rd = pc + imm;
                else if (opcode[T_JAL] || opcode[T_JALR]) e_rd = pc + 32'd4;
                else                                    e_rd = y;
                e_np_known = opcode[T_JAL] | opcode[T_JALR] | opcode[T_BRANCH];
                e_next_pc  = opcode[T_JALR] ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
                e_change_pc = opcode[T_JAL] | opcode[T_JALR] | (opcode[T_BRANCH] & y[0]);
                e_wr_rd = !(opcode[T_BRANCH] || opcode[T_STORE] || opcode[T_FENCE] ||
                            (opcode[T_SYSTEM] && funct3 == 3'd0));
                e_rd_valid = e_wr_rd & ~opcode[T_LOAD];
                e_sfa = opcode[T_LOAD] | opcode[T_STORE];
                e_rs1 = rs1; e_rs2 = rs2; e_pc = pc; e_imm = imm[11:0];
                e_rs1_addr = rs1_addr; e_rd_addr = rd_addr; e_funct3 = funct3;
                e_opcode = opcode; e_exception = exception;
            end else begin
                e_change_pc = 1'b0;
            end
            if (flush && !any)  e_ce = 1'b0;
            else if (!any)      e_ce = ce;
            else if (!stall)    e_ce = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("o_y", o_y, e_y);
        chk("o_rd", o_rd, e_rd);
        if (e_np_known) chk("o_next_pc", o_next_pc, e_next_pc);
        chk("o_change_pc", {31'd0, o_change_pc}, {31'd0, e_change_pc});
        chk("o_wr_rd", {31'd0, o_wr_rd}, {31'd0, e_wr_rd});
        chk("o_rd_valid", {31'd0, o_rd_valid}, {31'd0, e_rd_valid});
        chk("o_stall_from_alu", {31'd0, o_stall_from_alu}, {31'd0, e_sfa});
        chk("o_ce", {31'd0, o_ce}, {31'd0, e_ce});
        chk("o_rs1", o_rs1, e_rs1);
        chk("o_rs2", o_rs2, e_rs2);
        chk("o_pc", o_pc, e_pc);
        chk("o_imm", {20'd0, o_imm}, {20'd0, e_imm});
        chk("o_addrs", {22'd0, o_rs1_addr, o_rd_addr}, {22'd0, e_rs1_addr, e_rd_addr});
        chk("o_f3_opc_exc", {14'd0, o_funct3, o_opcode, o_exception},
            {14'd0, e_funct3, e_opcode, e_exception});
    endtask

    task automatic set_vec(input int opc, input int op, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] im, input logic [31:0] p);
        opcode = 11'd1 << opc;
        alu    = 14'd1 << op;
        rs1 = r1; rs2 = r2; imm = im; pc = p;
        funct3 = 3'd0; rs1_addr = 5'd3; rd_addr = 5'd7; exception = 4'd0;
        ce = 1'b1; stall = 1'b0; force_stall = 1'b0; flush = 1'b0; rst_n = 1'b1;
    endtask

    logic [31:0] itype_exp [14];
    logic [31:0] saved_y;

    initial begin
        n_vec = 0;
        n_err = 0;
        itype_exp = '{32'd22, 32'd2, 32'd0, 32'd0, 32'd6, 32'd14, 32'd8,
                      32'd12288, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1};
        set_vec(T_ITYPE, T_ADD, 32'd0, 32'd0, 32'd0, 32'd0);
        ce = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        step();
        chk("rst_ce", {31'd0, o_ce}, 32'd0);
        chk("rst_change_pc", {31'd0, o_change_pc}, 32'd0);
        chk("rst_wr_rd", {31'd0, o_wr_rd}, 32'd0);
        chk("rst_y", o_y, 32'd0);

        for (int k = 0; k < 14; k++) begin
            set_vec(T_ITYPE, k, 32'd12, 32'd0, 32'd10, 32'd0);
            step();
            chk("itype_sweep", o_y, itype_exp[k]);
        end

        set_vec(T_RTYPE, T_SRA, 32'h8000_0000, 32'd4, 32'd0, 32'd0);
        step(); chk("rtype_sra", o_y, 32'hF800_0000);
        set_vec(T_RTYPE, T_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        step(); chk("rtype_slt", o_y, 32'd1);
        set_vec(T_RTYPE, T_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        step(); chk("rtype_sltu", o_y, 32'd0);

        set_vec(T_BRANCH, T_EQ, 32'd5, 32'd5, 32'd8, 32'h100);
        step();
        chk("beq_taken", {31'd0, o_change_pc}, 32'd1);
        chk("beq_target", o_next_pc, 32'h108);
        chk("beq_wr_rd", {31'd0, o_wr_rd}, 32'd0);
        set_vec(T_BRANCH, T_EQ, 32'd5, 32'd6, 32'd8, 32'h100);
        step(); chk("beq_not_taken", {31'd0, o_change_pc}, 32'd0);

        set_vec(T_JAL, T_ADD, 32'd0, 32'd0, 32'h20, 32'h200);
        step();
        chk("jal_target", o_next_pc, 32'h220);
        chk("jal_link", o_rd, 32'h204);
        chk("jal_wr_rd", {31'd0, o_wr_rd}, 32'd1);
        set_vec(T_JALR, T_ADD, 32'h301, 32'd0, 32'd0, 32'h200);
        step(); chk("jalr_target", o_next_pc, 32'h300);
        ce = 1'b0;
        step(); chk("change_pc_pulse", {31'd0, o_change_pc}, 32'd0);

        set_vec(T_ITYPE, T_ADD, 32'd1, 32'd0, 32'd2, 32'd0);
        step();
        saved_y = o_y;
        set_vec(T_ITYPE, T_SUB, 32'd100, 32'd0, 32'd1, 32'd0);
        stall = 1'b1;
        step();
        chk("stall_hold", o_y, 32'd3);
        chk("stall_up", {31'd0, o_stall}, 32'd1);
        chk("stall_hold_saved", o_y, saved_y);
        stall = 1'b0; flush = 1'b1;
        step();
        chk("flush_ce", {31'd0, o_ce}, 32'd0);
        chk("flush_out", {31'd0, o_flush}, 32'd1);
        flush = 1'b1; stall = 1'b1;
        step();
        chk("flush_stall_up", {31'd0, o_stall}, 32'd0);

        for (int n = 0; n < 600; n++) begin
            opcode    = 11'd1 << $urandom_range(10, 0);
            alu       = 14'd1 << $urandom_range(13, 0);
            if ($urandom_range(15, 0) == 0) alu = 14'd0;
            if ($urandom_range(15, 0) == 1) alu = alu | (14'd1 << $urandom_range(13, 0));
            funct3    = 3'($urandom_range(7, 0));
            rs1       = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(40, 0)) : $urandom;
            rs2       = ($urandom_range(3, 0) == 0) ? rs1 : $urandom;
            imm       = ($urandom_range(1, 0) == 0) ? 32'($urandom_range(31, 0)) : $urandom;
            pc        = $urandom & 32'hFFFF_FFFC;
            rs1_addr  = 5'($urandom_range(31, 0));
            rd_addr   = 5'($urandom_range(31, 0));
            exception = 4'($urandom_range(15, 0));
            ce          = ($urandom_range(3, 0) != 0);
            stall       = ($urandom_range(5, 0) == 0);
            force_stall = ($urandom_range(7, 0) == 0);
            flush       = ($urandom_range(9, 0) == 0);
            rst_n       = ($urandom_range(49, 0) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
